// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared constants and request type for dmem_arbiter
package dmem_arb_pkg;

  localparam int PORT_CORE  = 0;
  localparam int PORT_DBG   = 1;
  localparam int NUM_PORTS  = 2;
  localparam int DMEM_WORDS = 1024;

  localparam int REQ_ADDR_W = 32;
  localparam int REQ_DATA_W = 32;

  // One requester access as seen by the forwarding logic
  typedef struct packed {
    logic                  we;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rtl/dmem_arbiter_rr_arb2.sv - 2-input round-robin picker with pointer register
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] gnt,
  output logic                 winner
);

  logic ptr_q, ptr_d;

  // Pick a winner; the pointer only breaks ties and then points at the loser
  always_comb begin
    gnt    = '0;
    winner = ptr_q;
    if (rst_n) begin
      case (req)
        2'b01: begin gnt = 2'b01; winner = 1'b0; end
        2'b10: begin gnt = 2'b10; winner = 1'b1; end
        2'b11: begin gnt = ptr_q ? 2'b10 : 2'b01; winner = ptr_q; end
        default: ;
      endcase
    end
    ptr_d = (|gnt) ? ~winner : ptr_q;
  end

  // Pointer register; reset favours the core port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin data memory arbiter (optional DMEM_ARB_ADDR_CHECK_EN)
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  logic [NUM_PORTS-1:0] req_vec, gnt_vec;
  logic                 winner;
  dmem_req_t            win_req;
  logic                 win_bad;
  logic                 fwd;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic                 rd_pending_q, rd_pending_d;
  logic                 rd_owner_q, rd_owner_d;

  assign req_vec[PORT_CORE] = req0;
  assign req_vec[PORT_DBG]  = req1;

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_vec),
    .gnt    (gnt_vec),
    .winner (winner)
  );

  assign gnt0 = gnt_vec[PORT_CORE];
  assign gnt1 = gnt_vec[PORT_DBG];

  // Gather the winning requester's access fields
  always_comb begin
    win_req.we    = we0;
    win_req.addr  = addr0;
    win_req.wdata = wdata0;
    if (winner) begin
      win_req.we    = we1;
      win_req.addr  = addr1;
      win_req.wdata = wdata1;
    end
  end

`ifdef DMEM_ARB_ADDR_CHECK_EN
  logic [NUM_PORTS-1:0] err_q, err_d;

  // Misaligned or out-of-window accesses are granted but never reach memory
  assign win_bad = (win_req.addr[1:0] != 2'b00) ||
                   (win_req.addr >= REQ_ADDR_W'(MEM_BYTES));

  // Error pulse goes to the granted port in the cycle after its grant
  always_comb begin
    err_d = ((|gnt_vec) && win_bad) ? gnt_vec : '0;
  end

  // Error pulse register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= '0;
    else        err_q <= err_d;
  end

  assign err0 = err_q[PORT_CORE];
  assign err1 = err_q[PORT_DBG];
`else
  logic unused_cfg;
  assign unused_cfg = (MEM_BYTES > 0);
  assign win_bad    = 1'b0;
  assign err0       = 1'b0;
  assign err1       = 1'b0;
`endif

  // Forwarding and read tracking; idle cycles hold the last address/data
  always_comb begin
    fwd          = (|gnt_vec) && !win_bad;
    addr_d       = fwd ? win_req.addr  : addr_q;
    wdata_d      = fwd ? win_req.wdata : wdata_q;
    rd_pending_d = fwd && !win_req.we;
    rd_owner_d   = rd_pending_d ? winner : rd_owner_q;
  end

  // Last-grant copy and in-flight read state; reset drops any pending response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_pending_q <= 1'b0;
      rd_owner_q   <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  assign mem_read       = fwd && !win_req.we;
  assign mem_write      = fwd && win_req.we;
  assign mem_address    = addr_d;
  assign mem_write_data = wdata_d;

  assign rvalid0 = rd_pending_q && !rd_owner_q;
  assign rvalid1 = rd_pending_q && rd_owner_q;
  assign rdata0  = rvalid0 ? mem_read_data : '0;
  assign rdata1  = rvalid1 ? mem_read_data : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_read, mem_write;
  logic [31:0] rdata0, rdata1, mem_address, mem_write_data, mem_read_data;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] mem [1024];

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  // Memory model: synchronous write, 1-cycle synchronous read
  always @(posedge clk) begin
    if (mem_write) mem[mem_address[11:2]] <= mem_write_data;
    if (mem_read)  mem_read_data <= mem[mem_address[11:2]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit p, input logic [31:0] a, input logic [31:0] d);
    tick();
    if (!p) begin req0 = 1'b1; we0 = 1'b1; addr0 = a; wdata0 = d; end
    else    begin req1 = 1'b1; we1 = 1'b1; addr1 = a; wdata1 = d; end
    tick();
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10; wdata0 = 32'h0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'h55;
    tick(); #1;
    n_cmp++; if ({gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_read, mem_write} !== 8'h00) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 00000000", {gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_read, mem_write}); end
    n_cmp++; if (mem_address !== 32'h0) begin
      n_fail++; $display("FAIL reset_addr: got %h want 0", mem_address); end
    n_cmp++; if (mem_write_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_wdata: got %h want 0", mem_write_data); end
    n_cmp++; if ({rdata0, rdata1} !== 64'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h want 0", {rdata0, rdata1}); end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    tick();
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h10; wdata0 = 32'hDEADBEEF; #1;
    n_cmp++; if ({gnt0, gnt1, mem_write, mem_read} !== 4'b1010) begin
      n_fail++; $display("FAIL wr_ctrl: got %b want 1010", {gnt0, gnt1, mem_write, mem_read}); end
    n_cmp++; if ({mem_address, mem_write_data} !== {32'h10, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL wr_fwd: got %h want 00000010deadbeef", {mem_address, mem_write_data}); end
    tick();
    we0 = 1'b0; #1;
    n_cmp++; if ({gnt0, gnt1, mem_write, mem_read, rvalid0} !== 5'b10010) begin
      n_fail++; $display("FAIL rd_ctrl: got %b want 10010", {gnt0, gnt1, mem_write, mem_read, rvalid0}); end
    tick();
    req0 = 1'b0; #1;
    n_cmp++; if ({rvalid0, rvalid1, gnt0, mem_read} !== 4'b1000) begin
      n_fail++; $display("FAIL rd_resp_ctrl: got %b want 1000", {rvalid0, rvalid1, gnt0, mem_read}); end
    n_cmp++; if (rdata0 !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL rd_resp_data: got %h want deadbeef", rdata0); end
    n_cmp++; if (mem_address !== 32'h10) begin
      n_fail++; $display("FAIL addr_hold: got %h want 00000010", mem_address); end
    tick(); #1;
    n_cmp++; if ({rvalid0, rdata0} !== 33'h0) begin
      n_fail++; $display("FAIL rd_idle: got %h want 0", {rvalid0, rdata0}); end
  endtask

  task automatic test_alternate();
    wr(1'b0, 32'h40, 32'hA0A0A0A0);
    wr(1'b1, 32'h80, 32'hB1B1B1B1);
    rst_n = 1'b0; #1; rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40;
      req1 = 1'b1; we1 = 1'b0; addr1 = 32'h80; #1;
      n_cmp++; if ({gnt1, gnt0} !== ((k % 2) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL alt_gnt%0d: got %b want %b", k, {gnt1, gnt0}, (k % 2) ? 2'b10 : 2'b01); end
      if (k > 0) begin
        n_cmp++; if ({rvalid1, rvalid0} !== ((k % 2) ? 2'b01 : 2'b10)) begin
          n_fail++; $display("FAIL alt_rv%0d: got %b want %b", k, {rvalid1, rvalid0}, (k % 2) ? 2'b01 : 2'b10); end
        n_cmp++; if ((k % 2) ? (rdata0 !== 32'hA0A0A0A0) : (rdata1 !== 32'hB1B1B1B1)) begin
          n_fail++; $display("FAIL alt_data%0d: got r0=%h r1=%h", k, rdata0, rdata1); end
      end
    end
    tick();
    req0 = 1'b0; req1 = 1'b0; #1;
    n_cmp++; if ({rvalid1, rvalid0, rdata1} !== {2'b10, 32'hB1B1B1B1}) begin
      n_fail++; $display("FAIL alt_last: got %b %h want 10 b1b1b1b1", {rvalid1, rvalid0}, rdata1); end
  endtask

  task automatic test_same_addr();
    tick();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40; #1;
    n_cmp++; if ({gnt1, gnt0} !== 2'b01) begin
      n_fail++; $display("FAIL same_pre: got %b want 01", {gnt1, gnt0}); end
    tick();
    addr0 = 32'h20; req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; wdata1 = 32'h5; #1;
    n_cmp++; if ({gnt1, gnt0, mem_write, mem_read, mem_address} !== {4'b1010, 32'h20}) begin
      n_fail++; $display("FAIL same_first: got %b %h want 1010 00000020", {gnt1, gnt0, mem_write, mem_read}, mem_address); end
    tick();
    req1 = 1'b0; #1;
    n_cmp++; if ({gnt1, gnt0, mem_read} !== 3'b011) begin
      n_fail++; $display("FAIL same_second: got %b want 011", {gnt1, gnt0, mem_read}); end
    tick();
    req0 = 1'b0; #1;
    n_cmp++; if ({rvalid0, rdata0} !== {1'b1, 32'h5}) begin
      n_fail++; $display("FAIL same_raw: got %b %h want 1 00000005", rvalid0, rdata0); end
  endtask

  task automatic test_reset_inflight();
    tick();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h20; #1;
    n_cmp++; if (gnt0 !== 1'b1) begin
      n_fail++; $display("FAIL rif_gnt: got %b want 1", gnt0); end
    tick();
    req0 = 1'b0; rst_n = 1'b0; #1;
    n_cmp++; if ({rvalid0, rvalid1} !== 2'b00) begin
      n_fail++; $display("FAIL rif_during: got %b want 00", {rvalid0, rvalid1}); end
    tick();
    rst_n = 1'b1; #1;
    n_cmp++; if ({rvalid0, rvalid1, rdata0} !== 34'h0) begin
      n_fail++; $display("FAIL rif_after: got %h want 0", {rvalid0, rvalid1, rdata0}); end
    tick();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40; req1 = 1'b1; we1 = 1'b0; addr1 = 32'h80; #1;
    n_cmp++; if ({rvalid0, rvalid1, gnt1, gnt0} !== 4'b0001) begin
      n_fail++; $display("FAIL rif_ptr: got %b want 0001", {rvalid0, rvalid1, gnt1, gnt0}); end
    tick();
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_back_to_back();
    wr(1'b0, 32'h0, 32'd1);
    wr(1'b0, 32'h4, 32'd2);
    wr(1'b0, 32'h8, 32'd3);
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k < 3) begin req0 = 1'b1; we0 = 1'b0; addr0 = 32'(4 * k); end
      else       req0 = 1'b0;
      #1;
      n_cmp++; if (gnt0 !== (k < 3)) begin
        n_fail++; $display("FAIL b2b_gnt%0d: got %b want %b", k, gnt0, k < 3); end
      n_cmp++; if (rvalid0 !== (k >= 1 && k <= 3)) begin
        n_fail++; $display("FAIL b2b_rv%0d: got %b want %b", k, rvalid0, k >= 1 && k <= 3); end
      if (k >= 1 && k <= 3) begin
        n_cmp++; if (rdata0 !== 32'(k)) begin
          n_fail++; $display("FAIL b2b_data%0d: got %h want %h", k, rdata0, 32'(k)); end
      end
    end
  endtask

  task automatic test_addr_check();
    tick();
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h1002; #1;
`ifdef DMEM_ARB_ADDR_CHECK_EN
    n_cmp++; if ({gnt1, mem_read, mem_write, err1} !== 4'b1000) begin
      n_fail++; $display("FAIL chk_gnt: got %b want 1000", {gnt1, mem_read, mem_write, err1}); end
    tick();
    req1 = 1'b0; #1;
    n_cmp++; if ({err1, err0, rvalid1} !== 3'b100) begin
      n_fail++; $display("FAIL chk_err: got %b want 100", {err1, err0, rvalid1}); end
    tick(); #1;
    n_cmp++; if ({err1, rvalid1} !== 2'b00) begin
      n_fail++; $display("FAIL chk_pulse: got %b want 00", {err1, rvalid1}); end
`else
    n_cmp++; if ({gnt1, mem_read, mem_write, mem_address} !== {3'b110, 32'h1002}) begin
      n_fail++; $display("FAIL wrap_fwd: got %b %h want 110 00001002", {gnt1, mem_read, mem_write}, mem_address); end
    tick();
    req1 = 1'b0; #1;
    n_cmp++; if ({err1, err0, rvalid1, rdata1} !== {3'b001, 32'd1}) begin
      n_fail++; $display("FAIL wrap_resp: got %b %h want 001 00000001", {err1, err0, rvalid1}, rdata1); end
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_alternate();
    test_same_addr();
    test_reset_inflight();
    test_back_to_back();
    test_addr_check();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (1024 x 32-bit; synchronous write; synchronous read with 1-cycle latency) between two requesters: port 0 = core load/store unit, port 1 = debug/DMA loader.
- Arbitrates round-robin and forwards one access per cycle.
- Tracks the in-flight read so read data returns to the correct requester.
- Sits between the MEM pipeline stage / debug bus and the data memory.

Parameters:
- ADDR_W, 32, byte-address width on requester and memory sides
- DATA_W, 32, data word width
- MEM_BYTES, 4096, memory window size in bytes; used only by the optional address check

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0 / req1  in  1  access request, port 0 / port 1
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W  byte address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  request accepted this cycle
- rvalid0 / rvalid1  out  1  read data valid this cycle
- rdata0 / rdata1  out  DATA_W  read data
- err0 / err1  out  1  access rejected (optional feature only; tied 0 otherwise)
- mem_read  out  1  to memory
- mem_write  out  1  to memory
- mem_address  out  ADDR_W  to memory
- mem_write_data  out  DATA_W  to memory
- mem_read_data  in  DATA_W  from memory; valid the cycle after mem_read

Behaviour:
- Reset (rst_n low, async):
  - rr_ptr = 0 (port 0 favoured); rd_pending = 0; rd_owner = 0.
  - All gnt/rvalid/err/mem_read/mem_write outputs forced 0.
  - mem_address and mem_write_data = 0.
- Requester handshake:
  - reqX, weX, addrX and wdataX are held stable until gntX.
  - gntX is combinational, asserted for exactly one cycle per access.
  - Requester may drop reqX the cycle after gnt, or keep it high to issue a back-to-back access.
- Arbitration, every cycle:
  - Only one requester active: it wins.
  - Both active: rr_ptr's port wins.
  - On any grant, rr_ptr <= index of the non-winning port.
  - No request: rr_ptr unchanged.
- Forwarding, same cycle as grant:
  - mem_address = winner addr; mem_write_data = winner wdata.
  - mem_write = winner we; mem_read = ~winner we.
  - No grant: mem_read = mem_write = 0.
  - mem_address and mem_write_data hold their last values (registered copy of the last grant) so the memory sees no glitches.
- Write latency: data is committed at the edge ending the grant cycle; the write has no response.
- Read latency:
  - Grant edge sets rd_pending <= 1 and rd_owner <= winner.
  - In the next cycle, rvalid[rd_owner] = 1 and rdata[rd_owner] = mem_read_data.
  - rd_pending clears unless a new read is granted that cycle.
  - rdataX is 0 whenever rvalidX = 0.
- Pipelining: a new grant is allowed in the same cycle as an rvalid, giving full throughput of one access per cycle.
- Read-after-write to the same address from either port returns the new data: the write commits before the read edge.
- Simultaneous requests to the same address from both ports: serialized in round-robin order, with no merging.
- Reset asserted with a read in flight: the response is dropped; no rvalid after reset release.

Optional Feature:
- Macro: DMEM_ARB_ADDR_CHECK_EN.
- When defined:
  - A request with addr[1:0] != 0 or addr >= MEM_BYTES still wins arbitration and gets gnt.
  - It is not forwarded: mem_read = mem_write = 0.
  - errX pulses for 1 cycle, in the cycle after the grant.
  - Rejected reads produce no rvalid. rr_ptr updates normally.
- When undefined:
  - No check; err0 and err1 are tied 0.
  - The memory ignores addr[1:0] and wraps above 4 KiB via addr[11:2].

Decomposition:
- Package dmem_arb_pkg holds:
  - PORT_CORE = 0, PORT_DBG = 1
  - NUM_PORTS = 2
  - DMEM_WORDS = 1024
  - typedef of the request struct {we, addr, wdata}
- One natural sub-module, rr_arb2: 2-input round-robin picker with pointer register, outputs grant one-hot plus winner index.
- Forwarding and read tracking stay in the top module.

Test Plan:
- Port 0 writes 0xDEADBEEF @0x10, then reads @0x10 → gnt0 each cycle; rvalid0 = 1 with rdata0 = 0xDEADBEEF exactly 1 cycle after the read grant; rvalid1 stays 0.
- req0 and req1 held high continuously, both reads from distinct addresses → grants alternate 0,1,0,1 starting with port 0 after reset; each rvalid goes to the correct owner with the correct data.
- Port 1 write 0x5 @0x20 and port 0 read @0x20 in the same cycle, rr_ptr = 1 → port 1 granted first; port 0 granted next cycle and reads 0x5.
- Read granted, then rst_n pulsed low for 1 cycle before the response → no rvalid0/1 after release; rr_ptr back to 0.
- Back-to-back reads by port 0 @0x0, 0x4, 0x8 (preloaded 1, 2, 3) → rvalid0 high 3 consecutive cycles with rdata 1, 2, 3.
- With DMEM_ARB_ADDR_CHECK_EN, port 1 reads @0x1002 → gnt1; mem_read stays 0; err1 pulses 1 cycle later; no rvalid1.
